muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter REGADDR_WIDTH, default 3, destination register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request strobe; accepted only when busy=0.
REQ-006 SHALL have port op  input  2  00 MUL (low half), 01 MULHU (high half), 10 DIVU, 11 REMU; all unsigned.
REQ-007 SHALL have port src_a  input  DATA_WIDTH  multiplicand / dividend.
REQ-008 SHALL have port src_b  input  DATA_WIDTH  multiplier / divisor.
REQ-009 SHALL have port dest_reg  input  REGADDR_WIDTH  writeback destination.
REQ-010 SHALL have port busy  output  1  high from the cycle after acceptance through the DONE cycle.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  unsupported-op flag, valid with done.
REQ-013 SHALL have ports wb_reg  output  REGADDR_WIDTH, wb_data  output  DATA_WIDTH, wb_en  output  1, driving the register file write_reg/write_data/reg_write port directly.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; start in IDLE moves to CALC, CALC exits to DONE after DATA_WIDTH iterations, DONE lasts exactly one cycle.
REQ-015 SHALL latch op, src_a, src_b, dest_reg on the accepting edge; later input changes do not affect the operation.
REQ-016 SHALL ignore start while busy=1, including in DONE; a new start is accepted in the first IDLE cycle after DONE.
REQ-017 SHALL perform multiply as radix-2 shift-add, one bit per CALC cycle, into a 2*DATA_WIDTH product register.
REQ-018 SHALL perform divide as restoring division, one quotient bit per CALC cycle, with DATA_WIDTH+1-bit partial remainder.
REQ-019 SHALL use a down-counter loaded with DATA_WIDTH on acceptance, decremented each CALC cycle; transition to DONE when it reaches 1 on a CALC edge.
REQ-020 SHALL assert done and wb_en for exactly one cycle, the (DATA_WIDTH+1)th cycle after the accepting cycle (cycle 17 for DATA_WIDTH=16).
REQ-021 SHALL present wb_reg = latched dest_reg and wb_data = selected result during the done cycle; both hold last value otherwise.
REQ-022 SHALL select result: MUL product[DATA_WIDTH-1:0]; MULHU product[2*DATA_WIDTH-1:DATA_WIDTH]; DIVU quotient; REMU remainder.
REQ-023 SHALL on divisor zero return quotient all-ones and remainder = dividend, with unchanged latency and err=0.
REQ-024 SHALL allow dest_reg 0 to be written like any other register.
REQ-025 SHALL keep wb_en low in all cycles other than DONE.

Reset
REQ-026 SHALL on reset high at a rising edge return to IDLE and clear busy, done, err, wb_en, wb_reg, wb_data, counter and datapath registers to 0.
REQ-027 SHALL abort an in-flight operation on reset with no wb_en pulse, even if reset coincides with the DONE cycle.
REQ-028 SHALL give reset priority over start in the same cycle.

Configuration
REQ-029 SHALL compile the divider datapath only when macro MULDIV_DIV_EN is defined.
REQ-030 SHALL without MULDIV_DIV_EN treat DIVU/REMU as unsupported: accepted, DONE after one CALC cycle, done=1, err=1, wb_en=0, wb_data=0; MUL/MULHU unchanged.
REQ-031 SHALL with MULDIV_DIV_EN defined never assert err.

Verification (DATA_WIDTH=16, MULDIV_DIV_EN defined unless stated)
REQ-032 MUL src_a=0x00FF, src_b=0x0101, dest_reg=5 -> done/wb_en on cycle 17, wb_reg=5, wb_data=0xFFFF; MULHU same operands -> 0x0000.
REQ-033 MULHU 0xFFFF x 0xFFFF, dest_reg=7 -> wb_data=0xFFFE; busy high cycles 1-17, low cycle 18.
REQ-034 DIVU 100/7 -> wb_data=0x000E; REMU 100/7 -> 0x0002; DIVU 0x1234/0 -> 0xFFFF; REMU 0x1234/0 -> 0x1234.
REQ-035 start with MUL 3x4, second start (DIVU) on cycles 5 and 17 -> both ignored, single wb_en with 0x000C; start on cycle 18 accepted.
REQ-036 reset asserted on cycle 10 of an operation -> busy=0, no done/wb_en pulse, all outputs 0 next cycle; new op afterwards completes correctly.
REQ-037 MULDIV_DIV_EN undefined: DIVU 100/7 -> done=1, err=1, wb_en=0 on cycle 2; MUL 3x4 still 0x000C on cycle 17.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply / divide unit, one bit per cycle.
//   op 00 MUL (low half), 01 MULHU (high half), 10 DIVU, 11 REMU.
//   The restoring divider is compiled only when MULDIV_DIV_EN is defined;
//   without it DIVU/REMU finish after one CALC cycle with err=1 and no
//   writeback.
// Accepting edge -> DATA_WIDTH CALC cycles -> one DONE cycle carrying
// done/wb_en/wb_reg/wb_data, all registered.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  input  logic [REGADDR_WIDTH-1:0] dest_reg,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [REGADDR_WIDTH-1:0] wb_reg,
  output logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     wb_en
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt;
  logic [1:0]               op_q;
  logic [W-1:0]             a_q;
  logic [REGADDR_WIDTH-1:0] dest_q;
  logic [2*W-1:0]           prod, prod_nxt;
  logic [W:0]               mul_sum;
  logic                     unsup;
  logic                     last_step;
  logic [W-1:0]             result;
`ifdef MULDIV_DIV_EN
  logic [W-1:0]             b_q;
  logic [W:0]               rem, rem_nxt;
  logic [W-1:0]             quo, quo_nxt;
  logic [W+1:0]             div_shift, div_diff;
  logic                     div_ge;
`endif

`ifdef MULDIV_DIV_EN
  assign unsup = 1'b0;
`else
  assign unsup = op_q[1];
`endif

  assign busy      = (state != S_IDLE);
  assign last_step = (state == S_CALC) && (unsup || cnt == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: unsupported ops skip straight to DONE after one CALC cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One shift-add / restoring-subtract step; the result mux looks at the
  // post-step values so the final step's answer is captured on the same edge.
  always_comb begin
    mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, a_q} : '0);
    prod_nxt = {mul_sum, prod[W-1:1]};
`ifdef MULDIV_DIV_EN
    // rem stays below the divisor, so its top bit is zero and the
    // W+2-bit difference exposes the borrow in bit W+1.
    div_shift = {rem, quo[W-1]};
    div_diff  = div_shift - {2'b00, b_q};
    div_ge    = ~div_diff[W+1];
    rem_nxt   = div_ge ? div_diff[W:0] : div_shift[W:0];
    quo_nxt   = {quo[W-2:0], div_ge};
`endif
    case (op_q)
      2'b00:   result = prod_nxt[W-1:0];
      2'b01:   result = prod_nxt[2*W-1:W];
`ifdef MULDIV_DIV_EN
      2'b10:   result = quo_nxt;
      default: result = rem_nxt[W-1:0];
`else
      default: result = '0;
`endif
    endcase
  end

  // Operand latch, iteration datapath and registered writeback outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      dest_q  <= '0;
      prod    <= '0;
`ifdef MULDIV_DIV_EN
      b_q     <= '0;
      rem     <= '0;
      quo     <= '0;
`endif
      done    <= 1'b0;
      err     <= 1'b0;
      wb_en   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      wb_en <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          cnt    <= CW'(DATA_WIDTH);
          op_q   <= op;
          a_q    <= src_a;
          dest_q <= dest_reg;
          prod   <= {{W{1'b0}}, src_b};
`ifdef MULDIV_DIV_EN
          b_q    <= src_b;
          rem    <= '0;
          quo    <= src_a;
`endif
        end
        S_CALC: begin
          cnt  <= cnt - CW'(1);
          prod <= prod_nxt;
`ifdef MULDIV_DIV_EN
          rem  <= rem_nxt;
          quo  <= quo_nxt;
`endif
          if (last_step) begin
            done    <= 1'b1;
            err     <= unsup;
            wb_en   <= ~unsup;
            wb_reg  <= dest_q;
            wb_data <= result;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table + scoreboard bench for muldiv_unit (DATA_WIDTH=16).
// Follows MULDIV_DIV_EN: with it undefined, DIVU/REMU are expected to report err.
module tb_muldiv_unit;
  localparam int W  = 16;
  localparam int RW = 3;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    op;
  logic [W-1:0]  src_a, src_b;
  logic [RW-1:0] dest_reg;
  logic          busy, done, err, wb_en;
  logic [RW-1:0] wb_reg;
  logic [W-1:0]  wb_data;

  muldiv_unit #(.DATA_WIDTH(W), .REGADDR_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .dest_reg(dest_reg), .busy(busy), .done(done), .err(err),
    .wb_reg(wb_reg), .wb_data(wb_data), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic [RW-1:0] dest;
    logic [W-1:0]  exp;
  } vec_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [RW-1:0] dest;
    logic          err;
    int            due;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic exp_t mk(input logic [1:0] o, input logic [W-1:0] ex, input logic [RW-1:0] d, input int acc);
    exp_t e;
    e.dest = d;
    if (!DIV_EN && o[1]) begin
      e.data = '0; e.err = 1'b1; e.due = acc + 2;
    end else begin
      e.data = ex; e.err = 1'b0; e.due = acc + W + 1;
    end
    return e;
  endfunction

  // Scoreboard: every done pulse pops one expectation; stray outputs are errors.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("latency", cyc, e.due);
          chk("err", {31'b0, err}, {31'b0, e.err});
          chk("wb_en", {31'b0, wb_en}, {31'b0, ~e.err});
          chk("wb_data", {16'b0, wb_data}, {16'b0, e.data});
          if (!e.err) chk("wb_reg", {29'b0, wb_reg}, {29'b0, e.dest});
        end
      end else if (wb_en !== 1'b0 || err !== 1'b0) begin
        n_cmp++; n_bad++;
        $display("FAIL stray_output: got wb_en=%b err=%b expected 0 outside done (cycle %0d)", wb_en, err, cyc);
      end
    end
  end

  task automatic drive(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [RW-1:0] d);
    op = o; src_a = a; src_b = b; dest_reg = d; start = 1'b1;
  endtask

  // Called at a negedge; issues once idle and returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [RW-1:0] d, input logic [W-1:0] ex, input bit push);
    int guard = 0;
    while (busy !== 1'b0 && guard < 60) begin @(negedge clk); guard++; end
    if (guard >= 60) chk("issue_timeout", 32'd1, 32'd0);
    drive(o, a, b, d);
    if (push) sbq.push_back(mk(o, ex, d, cyc));
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); src_a = W'($urandom); src_b = W'($urandom); dest_reg = RW'($urandom);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((sbq.size() != 0 || busy !== 1'b0) && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) begin
      chk("drain_timeout", sbq.size(), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    {31'b0, busy},    32'd0);
    chk({tag, "_done"},    {31'b0, done},    32'd0);
    chk({tag, "_err"},     {31'b0, err},     32'd0);
    chk({tag, "_wb_en"},   {31'b0, wb_en},   32'd0);
    chk({tag, "_wb_reg"},  {29'b0, wb_reg},  32'd0);
    chk({tag, "_wb_data"}, {16'b0, wb_data}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t tv[17];

  initial begin
    bit ok;
    tv[0]  = '{2'b00, 16'h00FF, 16'h0101, 3'd5, 16'hFFFF};
    tv[1]  = '{2'b01, 16'h00FF, 16'h0101, 3'd5, 16'h0000};
    tv[2]  = '{2'b01, 16'hFFFF, 16'hFFFF, 3'd7, 16'hFFFE};
    tv[3]  = '{2'b10, 16'd100,  16'd7,    3'd1, 16'h000E};
    tv[4]  = '{2'b11, 16'd100,  16'd7,    3'd2, 16'h0002};
    tv[5]  = '{2'b10, 16'h1234, 16'h0000, 3'd3, 16'hFFFF};
    tv[6]  = '{2'b11, 16'h1234, 16'h0000, 3'd4, 16'h1234};
    tv[7]  = '{2'b00, 16'd3,    16'd4,    3'd0, 16'h000C};
    tv[8]  = '{2'b00, 16'hFFFF, 16'hFFFF, 3'd6, 16'h0001};
    tv[9]  = '{2'b10, 16'hFFFF, 16'h0001, 3'd2, 16'hFFFF};
    tv[10] = '{2'b11, 16'hFFFF, 16'hFFFF, 3'd3, 16'h0000};
    for (int i = 11; i < 17; i++) begin
      tv[i].op = 2'($urandom); tv[i].a = W'($urandom); tv[i].b = W'($urandom);
      tv[i].dest = RW'($urandom);
      tv[i].exp = model(tv[i].op, tv[i].a, tv[i].b);
    end

    reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; dest_reg = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Table vectors, issued back to back.
    for (int i = 0; i < 17; i++)
      issue(tv[i].op, tv[i].a, tv[i].b, tv[i].dest, tv[i].exp, 1'b1);
    wait_drain();

    // busy high on cycles 1..17, low on cycle 18.
    drive(2'b01, 16'hFFFF, 16'hFFFF, 3'd7);
    sbq.push_back(mk(2'b01, 16'hFFFE, 3'd7, cyc));
    ok = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k <= 17) ok &= (busy === 1'b1);
      else chk("busy_low_c18", {31'b0, busy}, 32'd0);
    end
    chk("busy_high_c1_17", {31'b0, ok}, 32'd1);
    wait_drain();

    // Starts during CALC (cycle 5) and DONE (cycle 17) are ignored; cycle 18 is accepted.
    drive(2'b00, 16'd3, 16'd4, 3'd2);
    sbq.push_back(mk(2'b00, 16'h000C, 3'd2, cyc));
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5 || k == 17) drive(2'b10, 16'd100, 16'd7, 3'd6);
      if (k == 18) begin
        drive(2'b11, 16'd100, 16'd7, 3'd4);
        sbq.push_back(mk(2'b11, 16'h0002, 3'd4, cyc));
      end
    end
    wait_drain();

    // Reset on cycle 10 aborts the operation.
    issue(2'b00, 16'h1111, 16'h0003, 3'd1, 16'h0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("abort_c10");
    repeat (20) @(negedge clk);
    issue(2'b01, 16'h8000, 16'h0004, 3'd3, 16'h0002, 1'b1);
    wait_drain();

    // Reset on the last CALC cycle: the DONE pulse never appears.
    issue(2'b00, 16'd5, 16'd5, 3'd5, 16'h0, 1'b0);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_c16_done", {31'b0, done}, 32'd0);
    chk("abort_c16_wb_en", {31'b0, wb_en}, 32'd0);
    repeat (5) @(negedge clk);

    // Reset wins over start in the same cycle.
    reset = 1'b1;
    drive(2'b00, 16'd2, 16'd2, 3'd1);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_over_start", {31'b0, busy}, 32'd0);
    repeat (20) @(negedge clk);

    // Divider (or its absence) after everything above.
    issue(2'b10, 16'd100, 16'd7, 3'd0, 16'h000E, 1'b1);
    wait_drain();
    chk("scoreboard_empty", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
